leaf_credit_arbiter: RTL and testbench

LEAF_CREDIT_ARBITER -- requirements
Module: leaf_credit_arbiter

---
 rtl/leaf_credit_arbiter_pkg.sv | 12 +
 rtl/leaf_credit_arbiter_rr_arbiter.sv | 23 ++
 rtl/leaf_credit_arbiter.sv | 109 ++++++++++
 tb/tb_leaf_credit_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_credit_arbiter_pkg.sv
// leaf_credit_arbiter_pkg: BFT packet field offsets, type codes, credit ceiling and FSM states
package leaf_credit_arbiter_pkg;
    localparam int VALID_BIT = 48;
    localparam int DST_LSB = 41;
    localparam int SRC_LSB = 34;
    localparam int TYPE_LSB = 32;
    localparam int CREDIT_AMT_BITS = 8;
    localparam logic [1:0] TYPE_DATA = 2'b00;
    localparam logic [1:0] TYPE_CREDIT = 2'b01;
    localparam int CREDIT_MAX = 128;
    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/leaf_credit_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching from last_grant+1 modulo N
module rr_arbiter #(
    parameter int N = 7,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    always_comb begin
        gnt_idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last_grant) + k) % N]) begin
                any = 1'b1;
                gnt_idx = IW'((int'(last_grant) + k) % N);
            end
        end
    end
    assign gnt = any ? N'(1) << gnt_idx : '0;
endmodule

// File: rtl/leaf_credit_arbiter.sv
// leaf_credit_arbiter: credit-gated round-robin packer of user streams into BFT packets
module leaf_credit_arbiter import leaf_credit_arbiter_pkg::*; #(
    parameter int NUM_PORTS = 7,
    parameter int PAYLOAD_BITS = 32,
    parameter int PACKET_BITS = 49,
    parameter int NUM_LEAF_BITS = 3,
    parameter int NUM_PORT_BITS = 4,
    parameter int CREDIT_MAX = leaf_credit_arbiter_pkg::CREDIT_MAX
) (
    input  logic                                   clk_bft,
    input  logic                                   reset_bft,
    input  logic [NUM_PORTS*PAYLOAD_BITS-1:0]      din_user,
    input  logic [NUM_PORTS-1:0]                   vld_user,
    output logic [NUM_PORTS-1:0]                   ack_user,
    input  logic                                   cfg_we,
    input  logic [2:0]                             cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dst,
    input  logic [PACKET_BITS-1:0]                 din_credit,
    output logic [PACKET_BITS-1:0]                 dout_pkt,
    input  logic                                   dout_ready
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int RW = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam int SW = (CW > CREDIT_AMT_BITS ? CW : CREDIT_AMT_BITS) + 1;

    state_t state, state_nxt;
    logic [IW-1:0] last_grant, gnt_idx;
    logic [CW-1:0] credit [NUM_PORTS];
    logic [CW-1:0] credit_nxt [NUM_PORTS];
    logic [RW-1:0] route [NUM_PORTS];
    logic [NUM_PORTS-1:0] configured, eligible, gnt;
    logic any, grant, credit_hit;
    logic [NUM_PORT_BITS-1:0] credit_port;
    logic [CREDIT_AMT_BITS-1:0] credit_amt;
    logic [PACKET_BITS-1:0] pkt_nxt;
    logic credit_unused;

    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            eligible[p] = vld_user[p] && credit[p] != '0 && configured[p];
    end

    rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
        .req(eligible),
        .last_grant(last_grant),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .any(any)
    );

    // a grant is only possible when the output register is free or draining this cycle
    assign grant = any && !reset_bft && (state == IDLE || dout_ready);
    assign ack_user = grant ? gnt : '0;

    always_comb begin
        state_nxt = state;
        pkt_nxt = dout_pkt;
        if (grant) begin
            state_nxt = SEND;
            pkt_nxt = '0;
            pkt_nxt[VALID_BIT] = 1'b1;
            pkt_nxt[DST_LSB +: RW] = route[gnt_idx];
            pkt_nxt[SRC_LSB +: NUM_PORT_BITS] = NUM_PORT_BITS'(gnt_idx);
            pkt_nxt[TYPE_LSB +: 2] = TYPE_DATA;
            pkt_nxt[PAYLOAD_BITS-1:0] = din_user[gnt_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
        end else if (state == SEND && dout_ready) begin
            state_nxt = IDLE;
            pkt_nxt[VALID_BIT] = 1'b0;
        end
    end

    assign credit_port = din_credit[SRC_LSB +: NUM_PORT_BITS];
    assign credit_amt = din_credit[CREDIT_AMT_BITS-1:0];
    assign credit_hit = din_credit[VALID_BIT] && din_credit[TYPE_LSB +: 2] == TYPE_CREDIT
                        && credit_port < NUM_PORT_BITS'(NUM_PORTS);
    assign credit_unused = ^din_credit;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_credit
        logic [SW-1:0] sum;
        assign sum = SW'(credit[g]) - SW'(ack_user[g])
                     + ((credit_hit && credit_port == NUM_PORT_BITS'(g)) ? SW'(credit_amt) : '0);
        assign credit_nxt[g] = sum > SW'(CREDIT_MAX) ? CW'(CREDIT_MAX) : CW'(sum);
    end

    always_ff @(posedge clk_bft) begin
        if (reset_bft) begin
            state <= IDLE;
            dout_pkt <= '0;
            last_grant <= IW'(NUM_PORTS - 1);
            configured <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                credit[p] <= CW'(CREDIT_MAX);
                route[p] <= '0;
            end
        end else begin
            state <= state_nxt;
            dout_pkt <= pkt_nxt;
            credit <= credit_nxt;
            if (grant)
                last_grant <= gnt_idx;
            if (cfg_we && int'(cfg_port) < NUM_PORTS) begin
                route[cfg_port] <= cfg_dst;
                configured[cfg_port] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_leaf_credit_arbiter.sv
// tb_leaf_credit_arbiter: directed stimulus checked against a per-cycle behavioural model
module tb_leaf_credit_arbiter;
    logic clk_bft = 1'b0;
    logic reset_bft;
    logic [223:0] din_user;
    logic [6:0] vld_user, ack_user;
    logic cfg_we;
    logic [2:0] cfg_port;
    logic [6:0] cfg_dst;
    logic [48:0] din_credit, dout_pkt;
    logic dout_ready;

    int errors = 0, checks = 0;
    int m_credit[7], m_route[7], ack_cnt[7];
    bit m_cfg[7];
    int m_last;
    logic [48:0] m_pkt;
    int glog[$];

    always #5 clk_bft = ~clk_bft;

    leaf_credit_arbiter dut (
        .clk_bft(clk_bft), .reset_bft(reset_bft), .din_user(din_user), .vld_user(vld_user),
        .ack_user(ack_user), .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_dst(cfg_dst),
        .din_credit(din_credit), .dout_pkt(dout_pkt), .dout_ready(dout_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] pkt(input int leaf, input int dport, input int src, input logic [31:0] pay);
        return {1'b1, 3'(leaf), 4'(dport), 3'b000, 4'(src), 2'b00, pay};
    endfunction

    function automatic logic [48:0] cpkt(input int port, input int typ, input int amt);
        return {1'b1, 7'd0, 3'b000, 4'(port), 2'(typ), 24'd0, 8'(amt)};
    endfunction

    task automatic model_reset();
        m_pkt = '0;
        m_last = 6;
        for (int p = 0; p < 7; p++) begin
            m_credit[p] = 128;
            m_route[p] = 0;
            m_cfg[p] = 0;
        end
    endtask

    task automatic clear_cnt();
        for (int p = 0; p < 7; p++) ack_cnt[p] = 0;
        glog.delete();
    endtask

    // called away from the clock edge: predict ack/packet, compare, then advance the model
    task automatic model_step();
        int g;
        logic [6:0] ea;
        g = -1;
        ea = '0;
        if (!reset_bft && (!m_pkt[48] || dout_ready))
            for (int k = 1; k <= 7; k++)
                if (g < 0 && vld_user[(m_last + k) % 7] && m_credit[(m_last + k) % 7] > 0 && m_cfg[(m_last + k) % 7])
                    g = (m_last + k) % 7;
        if (g >= 0) ea[g] = 1'b1;
        chk("model_ack", 64'(ack_user), 64'(ea));
        chk("model_pkt", 64'(dout_pkt), 64'(m_pkt));
        for (int p = 0; p < 7; p++) if (ack_user[p]) begin
            ack_cnt[p]++;
            glog.push_back(p);
        end
        if (reset_bft) begin
            model_reset();
            return;
        end
        for (int p = 0; p < 7; p++) begin
            int c;
            c = m_credit[p] - (g == p ? 1 : 0);
            if (din_credit[48] && din_credit[33:32] == 2'b01 && int'(din_credit[37:34]) == p)
                c += int'(din_credit[7:0]);
            m_credit[p] = c > 128 ? 128 : c;
        end
        if (g >= 0) begin
            m_pkt = {1'b1, 7'(m_route[g]), 3'b000, 4'(g), 2'b00, din_user[g*32 +: 32]};
            m_last = g;
        end else if (m_pkt[48] && dout_ready) m_pkt[48] = 1'b0;
        if (cfg_we && cfg_port < 7) begin
            m_route[cfg_port] = int'(cfg_dst);
            m_cfg[cfg_port] = 1;
        end
    endtask

    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(negedge clk_bft);
            model_step();
            @(posedge clk_bft);
            #1;
        end
    endtask

    task automatic cfg(input int port, input int leaf, input int dport);
        cfg_we = 1'b1;
        cfg_port = 3'(port);
        cfg_dst = {3'(leaf), 4'(dport)};
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset_bft = 1'b1;
        vld_user = '0;
        cfg_we = 1'b0;
        cfg_port = '0;
        cfg_dst = '0;
        din_credit = '0;
        dout_ready = 1'b0;
        for (int p = 0; p < 7; p++) din_user[p*32 +: 32] = 32'hA000_0000 + 32'(p);
        model_reset();
        clear_cnt();
        @(posedge clk_bft);
        #1;
        chk("reset_pkt", 64'(dout_pkt), 64'd0);
        chk("reset_ack", 64'(ack_user), 64'd0);
        cycle();
        reset_bft = 1'b0;
        cfg(0, 5, 9);
        cfg(3, 2, 3);
        cfg(6, 7, 15);

        // round robin over ports 0,3,6 at one packet per cycle
        vld_user = 7'b1001001;
        dout_ready = 1'b1;
        clear_cnt();
        cycle();
        chk("rr_pkt0", 64'(dout_pkt), 64'(pkt(5, 9, 0, 32'hA000_0000)));
        cycle();
        chk("rr_pkt3", 64'(dout_pkt), 64'(pkt(2, 3, 3, 32'hA000_0003)));
        cycle();
        chk("rr_pkt6", 64'(dout_pkt), 64'(pkt(7, 15, 6, 32'hA000_0006)));
        cycle();
        chk("rr_len", 64'(glog.size()), 64'd4);
        if (glog.size() == 4) begin
            chk("rr_g0", 64'(glog[0]), 64'd0);
            chk("rr_g1", 64'(glog[1]), 64'd3);
            chk("rr_g2", 64'(glog[2]), 64'd6);
            chk("rr_g3", 64'(glog[3]), 64'd0);
        end
        vld_user = '0;
        cycle();
        chk("drain_valid", 64'(dout_pkt[48]), 64'd0);

        // back-pressure holds the packet and suppresses acks
        vld_user = 7'b0001000;
        dout_ready = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("hold_pkt", 64'(dout_pkt), 64'(pkt(2, 3, 3, 32'hA000_0003)));
            chk("hold_ack", 64'(ack_user), 64'd0);
        end
        dout_ready = 1'b1;
        #1;
        chk("ready_rise_ack", 64'(ack_user), 64'h08);
        cycle();
        vld_user = '0;
        cycle();

        // port 3 now holds 125 credits: grant plus return of 10 saturates at 128
        vld_user = 7'b0001000;
        din_credit = cpkt(3, 1, 10);
        clear_cnt();
        cycle();
        din_credit = '0;
        cycle(140);
        chk("sat_acks", 64'(ack_cnt[3]), 64'd129);
        vld_user = '0;
        cycle();

        // credit exhaustion and refill on port 2
        cfg(2, 1, 2);
        vld_user = 7'b0000100;
        clear_cnt();
        cycle(140);
        chk("exhaust_acks", 64'(ack_cnt[2]), 64'd128);
        chk("exhaust_block", 64'(ack_user[2]), 64'd0);
        din_credit = cpkt(7, 1, 5);
        cycle();
        din_credit = cpkt(2, 0, 5);
        cycle();
        din_credit = '0;
        cycle(3);
        chk("ignored_credit", 64'(ack_cnt[2]), 64'd128);
        vld_user = 7'b0000101;
        clear_cnt();
        cycle(3);
        chk("other_port_ok", 64'(ack_cnt[0]), 64'd3);
        chk("blocked_port", 64'(ack_cnt[2]), 64'd0);
        vld_user = 7'b0000100;
        din_credit = cpkt(2, 1, 5);
        clear_cnt();
        cycle();
        din_credit = '0;
        cycle(20);
        chk("refill_acks", 64'(ack_cnt[2]), 64'd5);
        vld_user = '0;
        cycle();

        // route rewrite while a packet is held leaves it intact
        vld_user = 7'b0000001;
        dout_ready = 1'b0;
        cycle();
        cfg(0, 1, 1);
        chk("cfg_inflight", 64'(dout_pkt), 64'(pkt(5, 9, 0, 32'hA000_0000)));
        dout_ready = 1'b1;
        cycle();
        chk("cfg_new_route", 64'(dout_pkt), 64'(pkt(1, 1, 0, 32'hA000_0000)));

        // reset while SEND drops the packet and clears the route table
        dout_ready = 1'b0;
        cycle();
        reset_bft = 1'b1;
        dout_ready = 1'b1;
        vld_user = 7'b1111111;
        #1;
        chk("reset_cycle_ack", 64'(ack_user), 64'd0);
        cycle();
        reset_bft = 1'b0;
        chk("reset_drop_pkt", 64'(dout_pkt), 64'd0);
        clear_cnt();
        cycle(10);
        chk("unconfigured_acks", 64'(glog.size()), 64'd0);
        cfg(4, 6, 4);
        clear_cnt();
        cycle(140);
        chk("reset_credit_full", 64'(ack_cnt[4]), 64'd128);
        chk("reset_others_idle", 64'(glog.size()), 64'd128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
